// File: rtl/wb_dsp_bus_master.sv
// wb_dsp_bus_master: Wishbone B3 burst master for the DSP core (optional watchdog: WB_DSP_MASTER_TIMEOUT_EN)
module wb_dsp_bus_master #(
  parameter int dw          = 32,
  parameter int aw          = 32,
  parameter int RETRY_LIMIT = 3,
  parameter int TIMEOUT     = 255
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic          req_start,
  input  logic          req_we,
  input  logic [aw-1:0] req_adr,
  input  logic [2:0]    req_len,
  input  logic [dw-1:0] wr_data,
  output logic          wr_data_ack,
  output logic [dw-1:0] rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i
);
  localparam logic [1:0] IDLE = 2'd0, BUS = 2'd1, RETRY = 2'd2, DONE = 2'd3;
  logic [1:0]    state;
  logic          we;
  logic [aw-1:0] adr;
  logic [2:0]    len, beat;
  logic [7:0]    rty_cnt;
  logic          err;
  logic          bus, last, timeout;
  assign bus         = state == BUS;
  assign last        = beat == len;
  assign wb_cyc_o    = bus;
  assign wb_stb_o    = bus;
  assign wb_we_o     = bus & we;
  assign wb_dat_o    = wb_we_o ? wr_data : '0;
  assign wb_sel_o    = 4'hF;
  assign wb_bte_o    = 2'b00;
  assign wb_adr_o    = adr + aw'(beat) * aw'(dw / 8);
  assign wb_cti_o    = len == 3'd0 ? 3'b000 : last ? 3'b111 : 3'b010;
  assign busy        = bus | (state == RETRY);
  assign done        = state == DONE;
  assign error       = done & err;
  assign wr_data_ack = bus & we & wb_ack_i & ~wb_err_i;
`ifdef WB_DSP_MASTER_TIMEOUT_EN
  logic [7:0] wdog;
  assign timeout = bus & ~(wb_ack_i | wb_err_i | wb_rty_i) & (wdog == 8'(TIMEOUT - 1));
  // watchdog counts silent BUS cycles, cleared by any response or by leaving BUS
  always_ff @(posedge wb_clk or negedge wb_rst_n)
    if (!wb_rst_n) wdog <= '0;
    else wdog <= (bus && !(wb_ack_i || wb_err_i || wb_rty_i)) ? wdog + 8'd1 : '0;
`else
  assign timeout = TIMEOUT < 0;
`endif
  // request sequencing: latch request, step beats on ack, handle err/rty/timeout
  always_ff @(posedge wb_clk or negedge wb_rst_n)
    if (!wb_rst_n) begin
      state    <= IDLE;
      we       <= 1'b0;
      adr      <= '0;
      len      <= '0;
      beat     <= '0;
      rty_cnt  <= '0;
      err      <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: if (req_start) begin
          state   <= BUS;
          we      <= req_we;
          adr     <= req_adr;
          len     <= req_len;
          beat    <= '0;
          rty_cnt <= '0;
          err     <= 1'b0;
        end
        BUS: if (wb_err_i) begin
          state <= DONE;
          err   <= 1'b1;
        end else if (wb_ack_i) begin
          rd_valid <= ~we;
          if (!we) rd_data <= wb_dat_i;
          if (last) state <= DONE;
          else beat <= beat + 3'd1;
        end else if (wb_rty_i) begin
          if (rty_cnt == 8'(RETRY_LIMIT)) begin
            state <= DONE;
            err   <= 1'b1;
          end else begin
            rty_cnt <= rty_cnt + 8'd1;
            state   <= RETRY;
          end
        end else if (timeout) begin
          state <= DONE;
          err   <= 1'b1;
        end
        RETRY: state <= BUS;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_wb_dsp_bus_master.sv
// tb_wb_dsp_bus_master: scoreboard bench with a behavioural Wishbone slave
module tb_wb_dsp_bus_master;
  localparam int RL = 3;
  logic        wb_clk = 1'b0, wb_rst_n = 1'b0;
  logic        req_start = 1'b0, req_we = 1'b0;
  logic [31:0] req_adr = '0;
  logic [2:0]  req_len = '0;
  logic [31:0] wr_data = '0;
  logic        wr_data_ack, rd_valid, busy, done, error;
  logic [31:0] rd_data, wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i, wb_rty_i;

  wb_dsp_bus_master #(.dw(32), .aw(32), .RETRY_LIMIT(RL), .TIMEOUT(255)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .req_start(req_start), .req_we(req_we),
    .req_adr(req_adr), .req_len(req_len), .wr_data(wr_data), .wr_data_ack(wr_data_ack),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .error(error),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i));

  always #5 wb_clk = ~wb_clk;

  function automatic logic [31:0] rdval(input logic [31:0] a);
    return a == 32'h10 ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  int err_beat = -1, n_rty = 0;
  bit silent = 1'b0;
  int sb, rc;
  logic [31:0] nadr;
  assign nadr = wb_ack_i ? wb_adr_o + 32'd4 : wb_adr_o;

  // registered-response slave: zero-wait burst, scripted rty count and err beat
  always @(posedge wb_clk or negedge wb_rst_n)
    if (!wb_rst_n) begin
      wb_ack_i <= 1'b0; wb_err_i <= 1'b0; wb_rty_i <= 1'b0; wb_dat_i <= '0; sb <= 0; rc <= 0;
    end else begin
      wb_ack_i <= 1'b0; wb_err_i <= 1'b0; wb_rty_i <= 1'b0;
      if (done) begin
        sb <= 0; rc <= 0;
      end else if (wb_cyc_o && wb_stb_o && !silent &&
                   (!(wb_ack_i || wb_err_i || wb_rty_i) || (wb_ack_i && wb_cti_o == 3'b010))) begin
        if (rc < n_rty) begin wb_rty_i <= 1'b1; rc <= rc + 1; end
        else if (sb == err_beat) wb_err_i <= 1'b1;
        else begin wb_ack_i <= 1'b1; sb <= sb + 1; wb_dat_i <= rdval(nadr); end
      end
    end

  typedef struct { logic [31:0] adr; logic [2:0] cti; logic [31:0] dat; } beat_t;
  beat_t       exp_beat[$];
  logic [31:0] exp_rd[$];
  int pass_n = 0, tot = 0;
  int gaps, cyc_n, wacks, done_n;
  logic exp_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tot++;
    assert (obs === expv) pass_n++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic push_exp(input bit we, input logic [31:0] adr, input logic [2:0] len, input int nack);
    for (int i = 0; i < nack; i++) begin
      beat_t b;
      b.adr = adr + 32'(i) * 32'd4;
      b.cti = len == 3'd0 ? 3'b000 : i == int'(len) ? 3'b111 : 3'b010;
      b.dat = we ? 32'(i + 1) : 32'd0;
      exp_beat.push_back(b);
      if (!we) exp_rd.push_back(rdval(b.adr));
    end
  endtask

  task automatic tick();
    beat_t b;
    @(negedge wb_clk);
    if (wb_cyc_o) cyc_n++;
    if (busy && !wb_cyc_o) gaps++;
    if (wb_cyc_o && wb_ack_i && !wb_err_i) begin
      if (exp_beat.size() == 0) chk("spurious ack", 32'(exp_beat.size()), 1);
      else begin
        b = exp_beat.pop_front();
        chk("adr", wb_adr_o, b.adr);
        chk("cti", 32'(wb_cti_o), 32'(b.cti));
        chk("dat_o", wb_dat_o, b.dat);
      end
    end
    if (wr_data_ack) begin wacks++; wr_data = wr_data + 32'd1; end
    if (rd_valid) begin
      if (exp_rd.size() == 0) chk("spurious rd_valid", 32'(exp_rd.size()), 1);
      else chk("rd_data", rd_data, exp_rd.pop_front());
    end
    if (done) begin
      done_n++;
      chk("busy at done", 32'(busy), 0);
      chk("cyc at done", 32'(wb_cyc_o), 0);
      chk("error", 32'(error), 32'(exp_err));
    end
  endtask

  task automatic start(input bit we, input logic [31:0] adr, input logic [2:0] len);
    wr_data = 32'd1; gaps = 0; cyc_n = 0; wacks = 0; done_n = 0;
    req_we = we; req_adr = adr; req_len = len; req_start = 1'b1;
    tick();
    req_start = 1'b0; req_we = ~we; req_adr = 32'hFFFF_FFF0; req_len = 3'd5;
    chk("cyc after start", 32'(wb_cyc_o), 1);
    chk("busy after start", 32'(busy), 1);
  endtask

  task automatic req(input bit we, input logic [31:0] adr, input logic [2:0] len,
                     input int eb, input int nr, input bit poke);
    int nack;
    err_beat = eb; n_rty = nr;
    exp_err = (eb >= 0) || (nr > RL);
    nack = nr > RL ? 0 : eb >= 0 ? eb : int'(len) + 1;
    push_exp(we, adr, len, nack);
    start(we, adr, len);
    for (int k = 0; k < 200 && done_n == 0; k++) begin
      req_start = poke && k == 1;
      tick();
    end
    req_start = 1'b0;
    tick(); tick();
    chk("done count", 32'(done_n), 1);
    chk("idle after", 32'(busy), 0);
    chk("wr acks", 32'(wacks), we ? 32'(nack) : 0);
    chk("retry gaps", 32'(gaps), nr > RL ? RL : 32'(nr));
    chk("beats left", 32'(exp_beat.size()), 0);
    chk("reads left", 32'(exp_rd.size()), 0);
  endtask

  initial begin
    tick(); tick();
    chk("rst cyc", 32'(wb_cyc_o), 0);
    chk("rst stb", 32'(wb_stb_o), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst rd_valid", 32'(rd_valid), 0);
    chk("rst adr", wb_adr_o, 0);
    chk("rst dat_o", wb_dat_o, 0);
    chk("rst cti", 32'(wb_cti_o), 0);
    wb_rst_n = 1'b1;
    tick();
    req(1'b0, 32'h10, 3'd0, -1, 0, 1'b0);
    req(1'b1, 32'h100, 3'd3, -1, 0, 1'b1);
    chk("burst cyc cycles", 32'(cyc_n), 5);
    req(1'b0, 32'h500, 3'd3, 1, 0, 1'b0);
    req(1'b0, 32'h200, 3'd1, -1, 2, 1'b0);
    req(1'b0, 32'h200, 3'd1, -1, 4, 1'b0);
    req(1'b1, 32'hFFFF_FFF8, 3'd2, -1, 0, 1'b0);
    err_beat = -1; n_rty = 0; exp_err = 1'b0;
    push_exp(1'b0, 32'h600, 3'd7, 8);
    start(1'b0, 32'h600, 3'd7);
    tick(); tick(); tick();
    chk("sel", 32'(wb_sel_o), 32'hF);
    chk("bte", 32'(wb_bte_o), 0);
    wb_rst_n = 1'b0;
    #1;
    chk("async rst cyc", 32'(wb_cyc_o), 0);
    chk("async rst stb", 32'(wb_stb_o), 0);
    chk("async rst busy", 32'(busy), 0);
    exp_beat.delete(); exp_rd.delete();
    tick();
    wb_rst_n = 1'b1;
    tick();
    req(1'b1, 32'h700, 3'd1, -1, 0, 1'b0);
    silent = 1'b1;
`ifdef WB_DSP_MASTER_TIMEOUT_EN
    exp_err = 1'b1;
    start(1'b0, 32'h400, 3'd0);
    for (int k = 0; k < 1000 && done_n == 0; k++) tick();
    chk("timeout done", 32'(done_n), 1);
    chk("timeout bus cycles", 32'(cyc_n), 255);
`else
    exp_err = 1'b0;
    start(1'b0, 32'h400, 3'd0);
    for (int k = 0; k < 1000; k++) tick();
    chk("still busy", 32'(busy), 1);
    chk("no done", 32'(done_n), 0);
    wb_rst_n = 1'b0;
    tick();
    wb_rst_n = 1'b1;
`endif
    $display("%0d/%0d checks passed", pass_n, tot);
    $finish;
  end
endmodule
